// File: rtl/ghost_mover.sv
// Ghost movement controller: owns one ghost's pixel position and heading and
// advances one pixel per step tick. On each tick the heading is picked from
// the active mode (random, chase, frightened, hold) and the blocked mask.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   en                      : 1 = tick counter runs and the ghost may move
//   mode                    : 0 random, 1 chase, 2 frightened, 3 hold
//   target_x, target_y      : chase target pixel
//   blocked                 : per-direction wall mask at the current x/y
//   x, y, direction         : registered ghost position and heading
//   step, turn              : one-cycle pulses on position/heading change
//   stuck                   : high while every direction is blocked
module ghost_mover #(
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned START_X     = 200,
  parameter int unsigned START_Y     = 146,
  parameter int unsigned MAX_X       = 639,
  parameter int unsigned STEP_PERIOD = 131072,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          TUNNEL_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [X_W-1:0] target_x,
  input  logic [Y_W-1:0] target_y,
  input  logic [3:0]     blocked,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     direction,
  output logic           step,
  output logic           turn,
  output logic           stuck
);

  localparam int unsigned CNT_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam int unsigned M_W   = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(MAX_X);
  localparam logic [15:0]      LFSR_MASK = 16'hB400;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;
  localparam logic [1:0] M_HOLD  = 2'd3;

  logic [CNT_W-1:0] cnt;
  logic [15:0]      lfsr;
  logic [1:0]       mode_q;

  logic             tick_c;
  logic [3:0]       eb_c;
  logic [1:0]       rev_c;
  logic             pending_c;
  logic [1:0]       nxt_dir_c;
  logic             move_c;
  logic [X_W-1:0]   nx_c;
  logic [Y_W-1:0]   ny_c;
  logic signed [X_W:0] dx_c;
  logic signed [Y_W:0] dy_c;
  logic [X_W:0]     ax_c;
  logic [Y_W:0]     ay_c;
  logic [1:0]       xdir_c;
  logic [1:0]       ydir_c;
  logic [3:0][1:0]  ord_c;
  logic [2:0]       scan_c;
  logic [2:0]       chase_c;

  // First free direction scanning start, start+1, ... (mod 4); optional skip.
  // Returns {found, dir}.
  function automatic logic [2:0] scan_free(input logic [3:0] mask,
                                           input logic [1:0] start,
                                           input logic [1:0] skip,
                                           input logic       use_skip);
    logic [2:0] r;
    logic [1:0] d;
    r = 3'b000;
    // Walk backwards so the earliest free candidate is the one left in r.
    for (int i = 3; i >= 0; i--) begin
      d = start + 2'(i);
      if (!mask[d] && !(use_skip && (d == skip))) r = {1'b1, d};
    end
    return r;
  endfunction

  // Next heading, move decision and next position for the current tick.
  always_comb begin
    tick_c    = en && (cnt == CNT_LAST);
    rev_c     = direction ^ 2'b01;
    pending_c = (mode != mode_q);

    eb_c = blocked;
    if (y == '0) eb_c[D_UP]   = 1'b1;
    if (&y)      eb_c[D_DOWN] = 1'b1;
    if (!TUNNEL_EN) begin
      if (x == '0)     eb_c[D_LEFT]  = 1'b1;
      if (x == X_LAST) eb_c[D_RIGHT] = 1'b1;
    end

    dx_c   = $signed({1'b0, target_x}) - $signed({1'b0, x});
    dy_c   = $signed({1'b0, target_y}) - $signed({1'b0, y});
    ax_c   = dx_c[X_W] ? (X_W+1)'(-dx_c) : (X_W+1)'(dx_c);
    ay_c   = dy_c[Y_W] ? (Y_W+1)'(-dy_c) : (Y_W+1)'(dy_c);
    xdir_c = dx_c[X_W] ? D_LEFT : D_RIGHT;
    ydir_c = dy_c[Y_W] ? D_UP : D_DOWN;
    if (M_W'(ax_c) >= M_W'(ay_c)) begin
      ord_c[0] = xdir_c;
      ord_c[1] = ydir_c;
    end else begin
      ord_c[0] = ydir_c;
      ord_c[1] = xdir_c;
    end
    ord_c[2] = ord_c[1] ^ 2'b01;
    ord_c[3] = ord_c[0] ^ 2'b01;

    chase_c = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (!eb_c[ord_c[i]] && (ord_c[i] != rev_c)) chase_c = {1'b1, ord_c[i]};
    end

    scan_c    = scan_free(eb_c, lfsr[1:0], rev_c, mode[1]);
    nxt_dir_c = direction;

    if (pending_c) begin
      if (!eb_c[rev_c]) nxt_dir_c = rev_c;
    end else begin
      unique case (mode)
        2'd0: begin
          if (eb_c[direction] && scan_c[2]) nxt_dir_c = scan_c[1:0];
        end
        2'd1: begin
          if (chase_c[2])         nxt_dir_c = chase_c[1:0];
          else if (!eb_c[rev_c])  nxt_dir_c = rev_c;
        end
        2'd2: begin
          if (scan_c[2])          nxt_dir_c = scan_c[1:0];
          else if (!eb_c[rev_c])  nxt_dir_c = rev_c;
        end
        default: nxt_dir_c = direction;
      endcase
    end

    move_c = !eb_c[nxt_dir_c] && (pending_c || (mode != M_HOLD));

    nx_c = x;
    ny_c = y;
    unique case (nxt_dir_c)
      D_UP:    ny_c = y - Y_W'(1);
      D_DOWN:  ny_c = y + Y_W'(1);
      D_LEFT:  nx_c = (x == '0) ? X_LAST : x - X_W'(1);
      default: nx_c = (x == X_LAST) ? '0 : x + X_W'(1);
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= X_W'(START_X);
      y         <= Y_W'(START_Y);
      direction <= D_UP;
      step      <= 1'b0;
      turn      <= 1'b0;
      stuck     <= 1'b0;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      mode_q    <= mode;
    end else begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
      step <= 1'b0;
      turn <= 1'b0;
      if (en) cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        mode_q    <= mode;
        stuck     <= &eb_c;
        direction <= nxt_dir_c;
        turn      <= (nxt_dir_c != direction);
        if (move_c) begin
          x    <= nx_c;
          y    <= ny_c;
          step <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: drives directed and random stimulus, predicts every
// cycle's outputs with an integer reference model, and a negedge monitor
// compares the DUT against the queued predictions.
module tb_ghost_mover;

  localparam int P      = 4;
  localparam int MAXX   = 639;
  localparam int YMAX   = 511;
  localparam int SX     = 200;
  localparam int SY     = 146;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [9:0] target_x = 10'd0;
  logic [8:0] target_y = 9'd0;
  logic [3:0] blocked = 4'd0;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] direction;
  logic       step, turn, stuck;

  ghost_mover #(
    .X_W(10), .Y_W(9), .START_X(SX), .START_Y(SY), .MAX_X(MAXX),
    .STEP_PERIOD(P), .LFSR_SEED(16'hACE1), .TUNNEL_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .target_x(target_x), .target_y(target_y), .blocked(blocked),
    .x(x), .y(y), .direction(direction),
    .step(step), .turn(turn), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int dir; bit step; bit turn; bit stuck;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state.
  int mx, my, mdir, mcnt, mlfsr, mmodeq;
  bit mstep, mturn, mstuck;
  int dxv[4] = '{0, 0, -1, 1};
  int dyv[4] = '{-1, 1, 0, 0};
  int opp[4] = '{1, 0, 3, 2};

  function automatic bit is_free(int d);
    int ny;
    ny = my + dyv[d];
    if (ny < 0 || ny > YMAX) return 1'b0;
    return !blocked[d];
  endfunction

  task automatic model_step();
    bit free[4];
    bit pending, moved, any;
    int l, rev, nd, dx, dy, xd, yd, ord[4];
    int c[$];
    if (rst) begin
      mx = SX; my = SY; mdir = 0; mstep = 0; mturn = 0; mstuck = 0;
      mcnt = 0; mlfsr = 'hACE1; mmodeq = int'(mode);
      return;
    end
    l = mlfsr % 4;
    mlfsr = (mlfsr & 1) ? ((mlfsr >> 1) ^ 'hB400) : (mlfsr >> 1);
    mstep = 0; mturn = 0;
    if (!en) return;
    if (mcnt != P - 1) begin mcnt++; return; end
    mcnt = 0;
    any = 0;
    for (int d = 0; d < 4; d++) begin free[d] = is_free(d); any |= free[d]; end
    rev = opp[mdir];
    pending = (int'(mode) != mmodeq);
    nd = mdir;
    if (pending) begin
      if (free[rev]) nd = rev;
    end else if (mode == 2'd0) begin
      if (!free[mdir])
        for (int k = 3; k >= 0; k--) if (free[(l + k) % 4]) nd = (l + k) % 4;
    end else if (mode == 2'd1) begin
      dx = int'(target_x) - mx; dy = int'(target_y) - my;
      xd = (dx < 0) ? 2 : 3; yd = (dy < 0) ? 0 : 1;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx >= dy) ord = '{xd, yd, opp[yd], opp[xd]};
      else          ord = '{yd, xd, opp[xd], opp[yd]};
      foreach (ord[k]) if (free[ord[k]] && ord[k] != rev) c.push_back(ord[k]);
      if (c.size() > 0) nd = c[0];
      else if (free[rev]) nd = rev;
    end else if (mode == 2'd2) begin
      for (int k = 0; k < 4; k++)
        if (free[(l + k) % 4] && (l + k) % 4 != rev) c.push_back((l + k) % 4);
      if (c.size() > 0) nd = c[0];
      else if (free[rev]) nd = rev;
    end
    moved = free[nd] && (pending || mode != 2'd3);
    mstuck = !any;
    mturn = (nd != mdir);
    mdir = nd;
    mmodeq = int'(mode);
    if (moved) begin
      mx = (mx + dxv[nd] + MAXX + 1) % (MAXX + 1);
      my = my + dyv[nd];
      mstep = 1;
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    e.x = mx; e.y = my; e.dir = mdir;
    e.step = mstep; e.turn = mturn; e.stuck = mstuck;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (int'(x) != e.x || int'(y) != e.y || int'(direction) != e.dir ||
          step != e.step || turn != e.turn || stuck != e.stuck) begin
        bad++;
        $display("FAIL outputs @%0t: got x=%0d y=%0d dir=%0d step=%0b turn=%0b stuck=%0b want x=%0d y=%0d dir=%0d step=%0b turn=%0b stuck=%0b",
                 $time, x, y, direction, step, turn, stuck,
                 e.x, e.y, e.dir, e.step, e.turn, e.stuck);
      end
    end
  end

  initial begin
    // Reset, then free run in random mode: climbs to y=0 and hits the edge.
    rst = 1; en = 1; mode = 0; blocked = 0;
    repeat (2) cycle();
    rst = 0;
    repeat (640) cycle();

    // Chase from the start position toward (210,146), then with right blocked.
    rst = 1; mode = 1; target_x = 10'd210; target_y = 9'd146;
    repeat (2) cycle();
    rst = 0;
    repeat (4 * P) cycle();
    blocked = 4'b1000;
    repeat (4 * P) cycle();

    // Mode change then full block then a single free direction.
    mode = 2; blocked = 0;
    repeat (P) cycle();
    blocked = 4'b1111;
    repeat (2 * P) cycle();
    blocked = 4'b1011;
    repeat (P) cycle();

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) blocked = 4'hF;
      else blocked = 4'($urandom & $urandom);
      if ($urandom_range(0, 49) == 0) begin
        target_x = 10'($urandom_range(0, MAXX));
        target_y = 9'($urandom_range(0, YMAX));
      end
      cycle();
    end

    // Tunnel: turn left once, then run across x=0 into MAX_X.
    rst = 1; en = 1; mode = 0; blocked = 0;
    repeat (2) cycle();
    rst = 0; blocked = 4'b1011;
    repeat (P) cycle();
    blocked = 0;
    repeat (205 * P) cycle();

    // Reset asserted on a tick cycle.
    for (int i = 0; i < P && mcnt != P - 1; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    repeat (3 * P) cycle();

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
